// File: rtl/comm_fifo_bridge.sv
// Elastic buffer between the SPI byte stream and the processing core: an RX FIFO of {cmd, data}
// pairs with a registered valid/ready head, and a TX FIFO drained into the SPI block by a small FSM.
module comm_fifo_bridge #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LVL_W      = 5,
  parameter int unsigned TX_HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       spi_cmd,
  input  logic [7:0]       spi_data_out,
  input  logic             spi_data_out_valid,
  output logic [7:0]       spi_data_in,
  output logic             spi_data_in_valid,
  input  logic             spi_data_in_free,
  output logic [7:0]       comm_cmd,
  output logic [7:0]       comm_data_in,
  output logic             comm_data_in_valid,
  input  logic             comm_data_in_ready,
  input  logic [7:0]       comm_data_out,
  input  logic             comm_data_out_valid,
  output logic             comm_data_out_free,
  output logic [LVL_W-1:0] rx_level,
  output logic [LVL_W-1:0] tx_level,
  output logic             rx_overflow,
  output logic             tx_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  // TX_HOLDOFF is expected to be at least 1
  localparam int unsigned CW = (TX_HOLDOFF > 1) ? $clog2(TX_HOLDOFF) : 1;
  localparam logic [CW-1:0] HoldLast = CW'(TX_HOLDOFF - 1);

  // ---------------- RX path ----------------
  logic [15:0]      rx_mem [DEPTH];
  logic [AW:0]      rx_wptr_q, rx_rptr_q;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic             rx_out_valid_q;
  logic [7:0]       rx_out_cmd_q, rx_out_data_q;
  logic [LVL_W-1:0] rx_level_q, rx_level_d;
  logic             rx_ovf_q;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  // Full is judged on the pre-edge state, so a push at full is refused even with a pop
  assign rx_push  = spi_data_out_valid && !rx_full;
  assign rx_pop   = !rx_empty && (!rx_out_valid_q || comm_data_in_ready);

  always_comb begin
    rx_level_d = rx_level_q;
    if (rx_push && !rx_pop) begin
      rx_level_d = rx_level_q + LVL_W'(1);
    end else if (!rx_push && rx_pop) begin
      rx_level_d = rx_level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wptr_q[AW-1:0]] <= {spi_cmd, spi_data_out};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr_q      <= '0;
      rx_rptr_q      <= '0;
      rx_out_valid_q <= 1'b0;
      rx_out_cmd_q   <= '0;
      rx_out_data_q  <= '0;
      rx_level_q     <= '0;
      rx_ovf_q       <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_wptr_q <= rx_wptr_q + 1'b1;
      end
      if (rx_pop) begin
        rx_rptr_q                     <= rx_rptr_q + 1'b1;
        {rx_out_cmd_q, rx_out_data_q} <= rx_mem[rx_rptr_q[AW-1:0]];
        rx_out_valid_q                <= 1'b1;
      end else if (comm_data_in_ready) begin
        rx_out_valid_q <= 1'b0;
      end
      rx_level_q <= rx_level_d;
      if (spi_data_out_valid && rx_full) begin
        rx_ovf_q <= 1'b1;
      end
    end
  end

  assign comm_cmd           = rx_out_cmd_q;
  assign comm_data_in       = rx_out_data_q;
  assign comm_data_in_valid = rx_out_valid_q;
  assign rx_level           = rx_level_q;
  assign rx_overflow        = rx_ovf_q;

  // ---------------- TX path ----------------
  typedef enum logic [1:0] {TxIdle, TxSend, TxWait} tx_state_e;

  logic [7:0]       tx_mem [DEPTH];
  logic [AW:0]      tx_wptr_q, tx_rptr_q;
  logic             tx_full, tx_empty, tx_push, tx_pop, tx_load;
  logic [LVL_W-1:0] tx_level_q, tx_level_d;
  logic             tx_ovf_q;
  logic [7:0]       tx_byte_q;
  tx_state_e        tx_state_q, tx_state_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign tx_push  = comm_data_out_valid && !tx_full;

  // Free is only looked at in TxIdle, so a stale flag cannot trigger a second send
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (!tx_empty && spi_data_in_free) begin
          tx_state_d = TxSend;
          tx_load    = 1'b1;
        end
      end
      TxSend: begin
        tx_pop     = 1'b1;
        tx_cnt_d   = '0;
        tx_state_d = TxWait;
      end
      TxWait: begin
        if (tx_cnt_q == HoldLast) begin
          tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx_level_d = tx_level_q;
    if (tx_push && !tx_pop) begin
      tx_level_d = tx_level_q + LVL_W'(1);
    end else if (!tx_push && tx_pop) begin
      tx_level_d = tx_level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr_q[AW-1:0]] <= comm_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
      tx_ovf_q   <= 1'b0;
      tx_byte_q  <= '0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
    end else begin
      if (tx_push) begin
        tx_wptr_q <= tx_wptr_q + 1'b1;
      end
      if (tx_pop) begin
        tx_rptr_q <= tx_rptr_q + 1'b1;
      end
      // Head is stable until the pop in TxSend, so it can be captured one cycle early
      if (tx_load) begin
        tx_byte_q <= tx_mem[tx_rptr_q[AW-1:0]];
      end
      if (comm_data_out_valid && tx_full) begin
        tx_ovf_q <= 1'b1;
      end
      tx_level_q <= tx_level_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign spi_data_in        = tx_byte_q;
  assign spi_data_in_valid  = (tx_state_q == TxSend);
  assign comm_data_out_free = (tx_level_q != LVL_W'(DEPTH));
  assign tx_level           = tx_level_q;
  assign tx_overflow        = tx_ovf_q;

endmodule

// File: tb/tb_comm_fifo_bridge.sv
// Randomised and directed bench for comm_fifo_bridge, checked against a queue-based reference
// model that tracks FIFO contents and TX strobe spacing in cycles.
module tb_comm_fifo_bridge;
  localparam int DEPTH = 16;
  localparam int LVL_W = 5;
  localparam int HOLD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic [7:0] spi_cmd = '0, spi_data_out = '0, comm_data_out = '0;
  logic spi_data_out_valid = 1'b0, spi_data_in_free = 1'b0;
  logic comm_data_in_ready = 1'b0, comm_data_out_valid = 1'b0;
  logic [7:0] spi_data_in, comm_cmd, comm_data_in;
  logic spi_data_in_valid, comm_data_in_valid, comm_data_out_free, rx_overflow, tx_overflow;
  logic [LVL_W-1:0] rx_level, tx_level;

  comm_fifo_bridge #(.DEPTH(DEPTH), .LVL_W(LVL_W), .TX_HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset),
    .spi_cmd(spi_cmd), .spi_data_out(spi_data_out), .spi_data_out_valid(spi_data_out_valid),
    .spi_data_in(spi_data_in), .spi_data_in_valid(spi_data_in_valid),
    .spi_data_in_free(spi_data_in_free),
    .comm_cmd(comm_cmd), .comm_data_in(comm_data_in), .comm_data_in_valid(comm_data_in_valid),
    .comm_data_in_ready(comm_data_in_ready),
    .comm_data_out(comm_data_out), .comm_data_out_valid(comm_data_out_valid),
    .comm_data_out_free(comm_data_out_free),
    .rx_level(rx_level), .tx_level(tx_level),
    .rx_overflow(rx_overflow), .tx_overflow(tx_overflow)
  );

  int n_vec = 0, n_bad = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  logic [15:0] m_rxq[$];
  logic [7:0]  m_txq[$];
  logic        m_out_v = 1'b0, m_rx_ovf = 1'b0, m_tx_ovf = 1'b0, m_tx_strobe = 1'b0;
  logic [7:0]  m_out_cmd = '0, m_out_data = '0, m_tx_byte = '0;
  int          m_since = HOLD + 1;  // cycles since the last TX strobe cycle
  int          rx_taken = 0;
  int          log_cyc[$];
  logic [7:0]  log_byte[$];

  task automatic model_edge();
    logic pop, push_ok, txp, start;
    logic [15:0] e;
    if (reset) begin
      m_rxq.delete(); m_txq.delete();
      m_out_v = 1'b0; m_out_cmd = '0; m_out_data = '0;
      m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_tx_strobe = 1'b0; m_tx_byte = '0;
      m_since = HOLD + 1;
      return;
    end
    pop     = (m_rxq.size() > 0) && (!m_out_v || comm_data_in_ready);
    push_ok = spi_data_out_valid && (m_rxq.size() < DEPTH);
    if (spi_data_out_valid && !push_ok) m_rx_ovf = 1'b1;
    if (m_out_v && comm_data_in_ready) begin
      m_out_v = 1'b0;
      rx_taken++;
    end
    if (pop) begin
      e = m_rxq.pop_front();
      m_out_cmd = e[15:8]; m_out_data = e[7:0]; m_out_v = 1'b1;
    end
    if (push_ok) m_rxq.push_back({spi_cmd, spi_data_out});

    txp   = comm_data_out_valid && (m_txq.size() < DEPTH);
    if (comm_data_out_valid && !txp) m_tx_ovf = 1'b1;
    start = (m_since >= HOLD + 1) && (m_txq.size() > 0) && spi_data_in_free;
    if (start) m_tx_byte = m_txq[0];
    if (m_tx_strobe) void'(m_txq.pop_front());
    m_tx_strobe = start;
    m_since = start ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
    if (txp) m_txq.push_back(comm_data_out);
  endtask

  task automatic compare_all();
    check_eq("rx_valid", 32'(comm_data_in_valid), 32'(m_out_v));
    if (m_out_v) begin
      check_eq("comm_cmd", 32'(comm_cmd), 32'(m_out_cmd));
      check_eq("comm_data_in", 32'(comm_data_in), 32'(m_out_data));
    end
    check_eq("rx_level", 32'(rx_level), 32'(m_rxq.size()));
    check_eq("tx_level", 32'(tx_level), 32'(m_txq.size()));
    check_eq("spi_valid", 32'(spi_data_in_valid), 32'(m_tx_strobe));
    check_eq("spi_data_in", 32'(spi_data_in), 32'(m_tx_byte));
    check_eq("out_free", 32'(comm_data_out_free), 32'(m_txq.size() < DEPTH));
    check_eq("rx_overflow", 32'(rx_overflow), 32'(m_rx_ovf));
    check_eq("tx_overflow", 32'(tx_overflow), 32'(m_tx_ovf));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    if (spi_data_in_valid) begin
      log_cyc.push_back(cyc);
      log_byte.push_back(spi_data_in);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] seen[$];
    int rx_sent, tx_sent, base_taken, nlog;
    logic done;

    // Reset state
    step(); step();
    reset = 1'b0;
    check_eq("rst_free", 32'(comm_data_out_free), 32'd1);
    check_eq("rst_rx_level", 32'(rx_level), 32'd0);
    check_eq("rst_rx_valid", 32'(comm_data_in_valid), 32'd0);

    // Single RX entry: two-cycle latency, then consumed
    spi_cmd = 8'h03; spi_data_out = 8'hA5; spi_data_out_valid = 1'b1;
    step();
    spi_data_out_valid = 1'b0;
    check_eq("t1_k1_valid", 32'(comm_data_in_valid), 32'd0);
    step();
    check_eq("t1_k2_valid", 32'(comm_data_in_valid), 32'd1);
    check_eq("t1_cmd", 32'(comm_cmd), 32'h03);
    check_eq("t1_data", 32'(comm_data_in), 32'hA5);
    comm_data_in_ready = 1'b1;
    step();
    comm_data_in_ready = 1'b0;
    check_eq("t1_after_valid", 32'(comm_data_in_valid), 32'd0);
    check_eq("t1_after_level", 32'(rx_level), 32'd0);

    // RX fill with the core stalled, then drain in order
    for (int i = 0; i < 18; i++) begin
      spi_cmd = 8'($urandom); spi_data_out = 8'(i); spi_data_out_valid = 1'b1;
      step();
    end
    spi_data_out_valid = 1'b0;
    step();
    check_eq("t2_rx_ovf", 32'(rx_overflow), 32'd1);
    check_eq("t2_rx_level", 32'(rx_level), 32'(DEPTH));
    comm_data_in_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (comm_data_in_valid) seen.push_back(comm_data_in);
      step();
    end
    comm_data_in_ready = 1'b0;
    check_eq("t2_count", 32'(seen.size()), 32'd17);
    for (int i = 0; i < seen.size(); i++) check_eq("t2_order", 32'(seen[i]), 32'(i));

    // TX: three bytes, strobes HOLD+2 apart
    do_reset();
    log_cyc.delete(); log_byte.delete();
    spi_data_in_free = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      comm_data_out = 8'(8'h11 * i); comm_data_out_valid = 1'b1;
      step();
    end
    comm_data_out_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("t3_count", 32'(log_cyc.size()), 32'd3);
    if (log_cyc.size() == 3) begin
      check_eq("t3_gap1", 32'(log_cyc[1] - log_cyc[0]), 32'(HOLD + 2));
      check_eq("t3_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'(HOLD + 2));
      for (int i = 0; i < 3; i++) check_eq("t3_byte", 32'(log_byte[i]), 32'(8'h11 * (i + 1)));
    end

    // TX fill with SPI busy
    log_cyc.delete(); log_byte.delete();
    spi_data_in_free = 1'b0;
    for (int i = 0; i < 17; i++) begin
      comm_data_out = 8'(8'h40 + i); comm_data_out_valid = 1'b1;
      step();
    end
    comm_data_out_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("t4_free", 32'(comm_data_out_free), 32'd0);
    check_eq("t4_level", 32'(tx_level), 32'(DEPTH));
    check_eq("t4_ovf", 32'(tx_overflow), 32'd1);
    check_eq("t4_no_strobe", 32'(log_cyc.size()), 32'd0);
    spi_data_in_free = 1'b1;
    for (int i = 0; i < DEPTH * (HOLD + 2) + 10; i++) step();
    check_eq("t4_drained", 32'(log_cyc.size()), 32'(DEPTH));
    for (int i = 0; i < log_byte.size(); i++) check_eq("t4_byte", 32'(log_byte[i]), 32'(8'h40 + i));

    // Random traffic both ways, crossing pointer wrap many times
    do_reset();
    log_cyc.delete(); log_byte.delete();
    rx_sent = 0; tx_sent = 0; base_taken = rx_taken; done = 1'b0;
    for (int c = 0; c < 30000 && !done; c++) begin
      spi_data_out_valid  = (rx_sent < 1000) && ($urandom_range(0, 2) == 0) &&
                            (m_rxq.size() < DEPTH);
      spi_cmd             = 8'($urandom);
      spi_data_out        = 8'($urandom);
      comm_data_in_ready  = ($urandom_range(0, 1) == 1);
      comm_data_out_valid = (tx_sent < 1000) && ($urandom_range(0, 4) == 0) &&
                            (m_txq.size() < DEPTH);
      comm_data_out       = 8'($urandom);
      spi_data_in_free    = ($urandom_range(0, 1) == 1);
      if (spi_data_out_valid) rx_sent++;
      if (comm_data_out_valid) tx_sent++;
      step();
      done = (rx_sent == 1000) && (tx_sent == 1000) && (m_rxq.size() == 0) && !m_out_v &&
             (m_txq.size() == 0) && !m_tx_strobe;
    end
    spi_data_out_valid = 1'b0; comm_data_out_valid = 1'b0; comm_data_in_ready = 1'b0;
    check_eq("t5_done", 32'(done), 32'd1);
    check_eq("t5_rx_ovf", 32'(rx_overflow), 32'd0);
    check_eq("t5_tx_ovf", 32'(tx_overflow), 32'd0);
    check_eq("t5_rx_taken", 32'(rx_taken - base_taken), 32'd1000);
    check_eq("t5_tx_strobes", 32'(log_cyc.size()), 32'd1000);

    // Reset mid-transfer with both FIFOs half full and the TX FSM holding off
    do_reset();
    spi_data_in_free = 1'b1;
    for (int i = 0; i < 10; i++) begin
      spi_data_out_valid  = (i < 8);
      spi_data_out        = 8'($urandom);
      comm_data_out_valid = 1'b1;
      comm_data_out       = 8'($urandom);
      step();
    end
    spi_data_out_valid = 1'b0; comm_data_out_valid = 1'b0;
    for (int i = 0; i < 20 && m_since != 1; i++) step();
    check_eq("t6_in_wait", 32'(m_since), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t6_rx_level", 32'(rx_level), 32'd0);
    check_eq("t6_tx_level", 32'(tx_level), 32'd0);
    check_eq("t6_rx_valid", 32'(comm_data_in_valid), 32'd0);
    check_eq("t6_spi_valid", 32'(spi_data_in_valid), 32'd0);
    check_eq("t6_free", 32'(comm_data_out_free), 32'd1);
    nlog = log_cyc.size();
    for (int i = 0; i < 12; i++) step();
    check_eq("t6_no_strobe", 32'(log_cyc.size()), 32'(nlog));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
